// File: rtl/alu_ex_stage.sv
// ALU execute stage: 2-entry output FIFO with registered branch resolution,
// writeback gating for branches/illegal opcodes, and retire/taken counters.
module alu_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_opcode,
  input  logic [DATA_W-1:0] in_alu_out,
  input  logic              in_compare,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [REG_W-1:0]  in_rd,
  input  logic              in_wr_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [REG_W-1:0]  out_rd,
  output logic              out_wr_en,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_target,
  output logic [31:0]       retired_count,
  output logic [31:0]       taken_count,
  output logic              illegal
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q;
  logic [DATA_W-1:0] head_result_q, tail_result_q;
  logic [REG_W-1:0]  head_rd_q, tail_rd_q;
  logic              head_wr_en_q, tail_wr_en_q;
  logic              branch_taken_q;
  logic [DATA_W-1:0] branch_target_q;
  logic [31:0]       retired_count_q, taken_count_q;
  logic              illegal_q;

  logic              accept_s, pop_s;
  logic              is_branch_s, is_illegal_s, entry_wr_en_s, take_s;
  logic [DATA_W-1:0] target_d;

  // Handshake, opcode classification and branch target arithmetic
  always_comb begin
    in_ready      = (state_q != FULL) && !branch_taken_q;
    out_valid     = (state_q != EMPTY);
    accept_s      = in_valid && in_ready;
    pop_s         = out_valid && out_ready;
    is_branch_s   = (in_opcode >= 5'd17) && (in_opcode <= 5'd22);
    is_illegal_s  = (in_opcode >= 5'd23);
    entry_wr_en_s = 1'b0;
    if (in_opcode <= 5'd16) begin
      entry_wr_en_s = in_wr_en;
    end else begin
      entry_wr_en_s = 1'b0;
    end
    take_s   = accept_s && is_branch_s && in_compare;
    // Immediate is a word offset, so shift left by two before adding.
    target_d = in_pc + DATA_W'(4) + {in_imm[DATA_W-3:0], 2'b00};
  end

  // FIFO control, branch resolution and status counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= EMPTY;
      head_result_q   <= '0;
      head_rd_q       <= '0;
      head_wr_en_q    <= 1'b0;
      tail_result_q   <= '0;
      tail_rd_q       <= '0;
      tail_wr_en_q    <= 1'b0;
      branch_taken_q  <= 1'b0;
      branch_target_q <= '0;
      retired_count_q <= 32'd0;
      taken_count_q   <= 32'd0;
      illegal_q       <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept_s) begin
            head_result_q <= in_alu_out;
            head_rd_q     <= in_rd;
            head_wr_en_q  <= entry_wr_en_s;
            state_q       <= ONE;
          end
        end
        ONE: begin
          if (accept_s && pop_s) begin
            head_result_q <= in_alu_out;
            head_rd_q     <= in_rd;
            head_wr_en_q  <= entry_wr_en_s;
          end else if (accept_s) begin
            tail_result_q <= in_alu_out;
            tail_rd_q     <= in_rd;
            tail_wr_en_q  <= entry_wr_en_s;
            state_q       <= FULL;
          end else if (pop_s) begin
            state_q <= EMPTY;
          end
        end
        FULL: begin
          if (pop_s) begin
            head_result_q <= tail_result_q;
            head_rd_q     <= tail_rd_q;
            head_wr_en_q  <= tail_wr_en_q;
            state_q       <= ONE;
          end
        end
        default: state_q <= EMPTY;
      endcase

      branch_taken_q <= take_s;
      if (take_s) begin
        branch_target_q <= target_d;
        taken_count_q   <= taken_count_q + 32'd1;
      end
      if (pop_s) begin
        retired_count_q <= retired_count_q + 32'd1;
      end
      if (accept_s && is_illegal_s) begin
        illegal_q <= 1'b1;
      end
    end
  end

  assign out_result    = head_result_q;
  assign out_rd        = head_rd_q;
  assign out_wr_en     = head_wr_en_q;
  assign branch_taken  = branch_taken_q;
  assign branch_target = branch_target_q;
  assign retired_count = retired_count_q;
  assign taken_count   = taken_count_q;
  assign illegal       = illegal_q;

endmodule

// File: tb/tb_alu_ex_stage.sv
// Directed bench for alu_ex_stage: table of single-entry vectors plus
// hand-written backpressure, illegal-opcode and async-reset sequences.
module tb_alu_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [4:0]  in_opcode;
  logic [31:0] in_alu_out, in_pc, in_imm;
  logic        in_compare;
  logic [3:0]  in_rd;
  logic        in_wr_en;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_rd;
  logic        out_wr_en;
  logic        branch_taken;
  logic [31:0] branch_target, retired_count, taken_count;
  logic        illegal;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_retired = 0;
  int exp_taken   = 0;
  logic [31:0] exp_target = 32'd0;

  alu_ex_stage #(.DATA_W(32), .REG_W(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_alu_out(in_alu_out), .in_compare(in_compare), .in_pc(in_pc),
    .in_imm(in_imm), .in_rd(in_rd), .in_wr_en(in_wr_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_wr_en(out_wr_en),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .retired_count(retired_count), .taken_count(taken_count),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] alu;
    logic        cmp;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [3:0]  rd;
    logic        wr;
    logic        exp_wr;
    logic        exp_tk;
    logic [31:0] exp_tgt;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] alu, input logic cmp,
                       input logic [31:0] pc, input logic [31:0] imm,
                       input logic [3:0] rd, input logic wr);
    in_valid   = 1'b1;
    in_opcode  = op;
    in_alu_out = alu;
    in_compare = cmp;
    in_pc      = pc;
    in_imm     = imm;
    in_rd      = rd;
    in_wr_en   = wr;
  endtask

  initial begin
    vecs[0] = '{5'd0,  32'd164,        1'b0, 32'h0,        32'h0,        4'd3,  1'b1, 1'b1, 1'b0, 32'h0};
    vecs[1] = '{5'd8,  32'hABCD_0000,  1'b0, 32'h0,        32'h0,        4'd7,  1'b1, 1'b1, 1'b0, 32'h0};
    vecs[2] = '{5'd16, 32'd1,          1'b1, 32'h40,       32'h1,        4'd15, 1'b1, 1'b1, 1'b0, 32'h0};
    vecs[3] = '{5'd19, 32'h5555_AAAA,  1'b1, 32'h100,      32'd5,        4'd2,  1'b1, 1'b0, 1'b1, 32'h118};
    vecs[4] = '{5'd22, 32'd9,          1'b0, 32'h200,      32'd3,        4'd4,  1'b1, 1'b0, 1'b0, 32'h0};
    vecs[5] = '{5'd17, 32'd0,          1'b1, 32'hFFFF_FFF0, 32'hFFFF_FFF8, 4'd1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFD4};
    vecs[6] = '{5'd22, 32'd77,         1'b1, 32'hFFFF_FFFC, 32'h0,       4'd6,  1'b1, 1'b0, 1'b1, 32'h0};
    vecs[7] = '{5'd7,  32'hDEAD_BEEF,  1'b0, 32'h0,        32'h0,        4'd9,  1'b0, 1'b0, 1'b0, 32'h0};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_opcode = 5'd0; in_alu_out = 32'd0; in_compare = 1'b0;
    in_pc = 32'd0; in_imm = 32'd0; in_rd = 4'd0; in_wr_en = 1'b0;
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", out_result, 32'd0);
    chk("rst_target", branch_target, 32'd0);
    chk("rst_retired", retired_count, 32'd0);
    reset = 1'b0;
    step();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);

    // Single-entry vectors, downstream always ready
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].op, vecs[i].alu, vecs[i].cmp, vecs[i].pc, vecs[i].imm, vecs[i].rd, vecs[i].wr);
      step();
      in_valid = 1'b0;
      if (vecs[i].exp_tk) begin
        exp_taken++;
        exp_target = vecs[i].exp_tgt;
      end
      chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("v%0d_result", i), out_result, vecs[i].alu);
      chk($sformatf("v%0d_rd", i), {28'd0, out_rd}, {28'd0, vecs[i].rd});
      chk($sformatf("v%0d_wr_en", i), {31'd0, out_wr_en}, {31'd0, vecs[i].exp_wr});
      chk($sformatf("v%0d_taken", i), {31'd0, branch_taken}, {31'd0, vecs[i].exp_tk});
      chk($sformatf("v%0d_target", i), branch_target, exp_target);
      chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, {31'd0, ~vecs[i].exp_tk});
      chk($sformatf("v%0d_taken_cnt", i), taken_count, exp_taken);
      step();
      exp_retired++;
      chk($sformatf("v%0d_empty", i), {31'd0, out_valid}, 32'd0);
      chk($sformatf("v%0d_taken_drop", i), {31'd0, branch_taken}, 32'd0);
      chk($sformatf("v%0d_target_hold", i), branch_target, exp_target);
      chk($sformatf("v%0d_retired", i), retired_count, exp_retired);
    end
    chk("no_illegal_yet", {31'd0, illegal}, 32'd0);

    // Backpressure: two entries fill the FIFO, third is held off
    out_ready = 1'b0;
    drive(5'd0, 32'hA, 1'b0, 32'h0, 32'h0, 4'd10, 1'b1);
    step();
    chk("bp_ready_one", {31'd0, in_ready}, 32'd1);
    drive(5'd1, 32'hB, 1'b0, 32'h0, 32'h0, 4'd11, 1'b1);
    step();
    chk("bp_full_ready", {31'd0, in_ready}, 32'd0);
    drive(5'd2, 32'hC, 1'b0, 32'h0, 32'h0, 4'd12, 1'b1);
    step();
    chk("bp_held_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_head_a", out_result, 32'hA);
    chk("bp_no_retire", retired_count, exp_retired);
    out_ready = 1'b1;
    step();
    exp_retired++;
    chk("bp_head_b", out_result, 32'hB);
    chk("bp_rd_b", {28'd0, out_rd}, 32'd11);
    chk("bp_ready_after_pop", {31'd0, in_ready}, 32'd1);
    step();
    exp_retired++;
    in_valid = 1'b0;
    chk("bp_head_c", out_result, 32'hC);
    chk("bp_rd_c", {28'd0, out_rd}, 32'd12);
    step();
    exp_retired++;
    chk("bp_drained", {31'd0, out_valid}, 32'd0);
    chk("bp_retired", retired_count, exp_retired);

    // Illegal opcode: passed through without writeback, flag sticks
    drive(5'b11000, 32'h1234, 1'b1, 32'h0, 32'h4, 4'd5, 1'b1);
    step();
    in_valid = 1'b0;
    chk("ill_flag", {31'd0, illegal}, 32'd1);
    chk("ill_wr_en", {31'd0, out_wr_en}, 32'd0);
    chk("ill_no_branch", {31'd0, branch_taken}, 32'd0);
    step(); step(); step();
    exp_retired++;
    chk("ill_sticky", {31'd0, illegal}, 32'd1);
    chk("ill_retired", retired_count, exp_retired);

    // Asynchronous reset while FULL, asserted between clock edges
    out_ready = 1'b0;
    drive(5'd0, 32'h11, 1'b0, 32'h0, 32'h0, 4'd1, 1'b1);
    step();
    drive(5'd0, 32'h22, 1'b0, 32'h0, 32'h0, 4'd2, 1'b1);
    step();
    in_valid = 1'b0;
    chk("ar_full", {31'd0, in_ready}, 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("ar_out_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_retired", retired_count, 32'd0);
    chk("ar_taken_cnt", taken_count, 32'd0);
    chk("ar_illegal", {31'd0, illegal}, 32'd0);
    chk("ar_target", branch_target, 32'd0);
    chk("ar_result", out_result, 32'd0);
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    step(); step();
    chk("ar_post_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_post_retired", retired_count, 32'd0);
    chk("ar_post_ready", {31'd0, in_ready}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
